// File: rtl/mips32r2_tlb_probe_pkg.sv
// Shared types for the MIPS32r2 TLB probe engine.
// Compare slice layout, FSM states and the per-entry match rule.
package mips32r2_tlb_probe_pkg;

  localparam int TLB_CMP_W = 44;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [15:0] mask;
    logic [7:0]  asid;
    logic        g;
  } TLBCmpSlice;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } state_e;

  // PageMask widens the ignored VPN2 bits; global entries ignore ASID.
  function automatic logic slice_match(
    input TLBCmpSlice  s,
    input logic [18:0] key_vpn2,
    input logic [7:0]  key_asid
  );
    logic vpn_ok;
    vpn_ok = ((s.vpn2 ^ key_vpn2) & ~{3'b000, s.mask}) == 19'd0;
    return vpn_ok && (s.g || (s.asid == key_asid));
  endfunction

endpackage

// File: rtl/mips32r2_tlb_group_match.sv
// Compares one group of TLB slices against a probe key.
// The lowest matching slot wins.
module mips32r2_tlb_group_match
  import mips32r2_tlb_probe_pkg::*;
#(
  parameter int GROUP_SIZE = 4,
  parameter int SLOT_W     = 2
) (
  input  logic [GROUP_SIZE*TLB_CMP_W-1:0] slices,
  input  logic [18:0]                     key_vpn2,
  input  logic [7:0]                      key_asid,
  output logic                            hit,
  output logic [SLOT_W-1:0]               slot
);

  always_comb begin
    hit  = 1'b0;
    slot = '0;
    for (int s = GROUP_SIZE - 1; s >= 0; s--) begin
      if (slice_match(TLBCmpSlice'(slices[s*TLB_CMP_W +: TLB_CMP_W]),
                      key_vpn2, key_asid)) begin
        hit  = 1'b1;
        slot = SLOT_W'(s);
      end
    end
  end

endmodule

// File: rtl/mips32r2_tlb_probe_engine.sv
// Round-robin multi-channel TLB probe engine.
// Group-serial search with early hit exit and deterministic miss.
module mips32r2_tlb_probe_engine
  import mips32r2_tlb_probe_pkg::*;
#(
  parameter  int NUM_ENTRIES  = 64,
  parameter  int GROUP_SIZE   = 4,
  parameter  int NUM_CHANNELS = 3,
  localparam int NUM_GROUPS   = NUM_ENTRIES / GROUP_SIZE,
  localparam int IDX_W        = $clog2(NUM_ENTRIES),
  localparam int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int GI_W         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1,
  localparam int SLOT_W       = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_CHANNELS-1:0]         req_valid,
  input  logic [NUM_CHANNELS*19-1:0]      req_ivpn2,
  input  logic [NUM_CHANNELS*8-1:0]       req_asid,
  output logic [NUM_CHANNELS-1:0]         resp_valid,
  output logic                            resp_hit,
  output logic [IDX_W-1:0]                resp_index,
  output logic                            grp_rd_en,
  output logic [GI_W-1:0]                 grp_rd_index,
  input  logic [GROUP_SIZE*TLB_CMP_W-1:0] grp_rd_data,
  input  logic                            w_valid
);

  localparam int RP_W = GI_W + 1;

  state_e            state;
  logic [CH_W-1:0]   owner;
  logic [CH_W-1:0]   rr;
  logic [CH_W-1:0]   grant_ch;
  logic [CH_W-1:0]   next_rr;
  logic              grant_any;
  logic [18:0]       key_vpn2;
  logic [7:0]        key_asid;
  logic [RP_W-1:0]   rd_ptr;
  logic [GI_W-1:0]   cmp_ptr;
  logic              cmp_valid;
  logic              owner_valid;
  logic              scan_issue;
  logic              last_grp;
  logic              m_hit;
  logic [SLOT_W-1:0] m_slot;
  logic [IDX_W-1:0]  hit_idx;

  // Descending scan so the smallest offset from rr wins.
  always_comb begin
    int c;
    c         = 0;
    grant_any = 1'b0;
    grant_ch  = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      c = (int'(rr) + i) % NUM_CHANNELS;
      if (req_valid[c]) begin
        grant_any = 1'b1;
        grant_ch  = CH_W'(c);
      end
    end
  end

  assign next_rr = (owner == CH_W'(NUM_CHANNELS - 1)) ? '0 : owner + 1'b1;

  assign owner_valid = req_valid[owner];
  assign last_grp    = cmp_ptr == GI_W'(NUM_GROUPS - 1);
  assign scan_issue  = (state == SCAN) && owner_valid && !w_valid &&
                       (rd_ptr < RP_W'(NUM_GROUPS));

  assign grp_rd_en    = !reset &&
                        (((state == IDLE) && grant_any) || scan_issue);
  assign grp_rd_index = (!reset && scan_issue) ? rd_ptr[GI_W-1:0] : '0;

  mips32r2_tlb_group_match #(
    .GROUP_SIZE (GROUP_SIZE),
    .SLOT_W     (SLOT_W)
  ) u_match (
    .slices   (grp_rd_data),
    .key_vpn2 (key_vpn2),
    .key_asid (key_asid),
    .hit      (m_hit),
    .slot     (m_slot)
  );

  assign hit_idx = IDX_W'(cmp_ptr) * IDX_W'(GROUP_SIZE) + IDX_W'(m_slot);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      rr         <= '0;
      key_vpn2   <= '0;
      key_asid   <= '0;
      rd_ptr     <= '0;
      cmp_ptr    <= '0;
      cmp_valid  <= 1'b0;
      resp_valid <= '0;
      resp_hit   <= 1'b0;
      resp_index <= '0;
    end else begin
      resp_valid <= '0;
      resp_hit   <= 1'b0;
      resp_index <= '0;
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            owner    <= grant_ch;
            key_vpn2 <= req_ivpn2[int'(grant_ch)*19 +: 19];
            key_asid <= req_asid[int'(grant_ch)*8 +: 8];
            cmp_ptr  <= '0;
            state    <= SCAN;
            // A write in the grant cycle makes group 0's read stale.
            if (w_valid) begin
              rd_ptr    <= '0;
              cmp_valid <= 1'b0;
            end else begin
              rd_ptr    <= RP_W'(1);
              cmp_valid <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (!owner_valid) begin
            state <= IDLE;
            rr    <= next_rr;
          end else if (w_valid) begin
            rd_ptr    <= '0;
            cmp_valid <= 1'b0;
          end else if (cmp_valid && (m_hit || last_grp)) begin
            resp_valid <= NUM_CHANNELS'(1) << owner;
            resp_hit   <= m_hit;
            resp_index <= m_hit ? hit_idx : '0;
            state      <= RESP;
          end else begin
            cmp_valid <= scan_issue;
            cmp_ptr   <= rd_ptr[GI_W-1:0];
            if (scan_issue) rd_ptr <= rd_ptr + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          rr    <= next_rr;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips32r2_tlb_probe_engine.sv
// Directed bench for the TLB probe engine with a behavioural
// group-read memory (one-cycle latency) holding the compare slices.
module tb_mips32r2_tlb_probe_engine;

  localparam int NE = 64;
  localparam int GS = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [2:0]   req_valid;
  logic [56:0]  req_ivpn2;
  logic [23:0]  req_asid;
  logic [2:0]   resp_valid;
  logic         resp_hit;
  logic [5:0]   resp_index;
  logic         grp_rd_en;
  logic [3:0]   grp_rd_index;
  logic [175:0] grp_rd_data;
  logic         w_valid;

  logic [43:0] mem [NE];

  int checks   = 0;
  int failures = 0;

  mips32r2_tlb_probe_engine dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ivpn2    (req_ivpn2),
    .req_asid     (req_asid),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_index   (resp_index),
    .grp_rd_en    (grp_rd_en),
    .grp_rd_index (grp_rd_index),
    .grp_rd_data  (grp_rd_data),
    .w_valid      (w_valid)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (grp_rd_en) begin
      for (int s = 0; s < GS; s++)
        grp_rd_data[s*44 +: 44] <= mem[{grp_rd_index, 2'(s)}];
    end
  end

  function automatic logic [43:0] mk(
    input logic [18:0] v,
    input logic [15:0] m,
    input logic [7:0]  a,
    input logic        g
  );
    return {v, m, a, g};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int ch, input logic v,
                         input logic [18:0] vpn, input logic [7:0] asid);
    req_valid[ch]          = v;
    req_ivpn2[ch*19 +: 19] = vpn;
    req_asid[ch*8 +: 8]    = asid;
  endtask

  // Latency counts clock edges from the cycle the call starts in.
  task automatic wait_resp(input string tag, input int ch, input int lat,
                           input logic hit, input logic [5:0] idx);
    int got;
    got = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (resp_valid != 3'b000) begin
        got = k;
        break;
      end
    end
    chk({tag, "_lat"}, got, lat);
    chk({tag, "_ch"}, 32'(resp_valid), 32'(1) << ch);
    chk({tag, "_hit"}, 32'(resp_hit), 32'(hit));
    chk({tag, "_idx"}, 32'(resp_index), 32'(idx));
  endtask

  task automatic quiet(input string tag);
    tick();
    chk(tag, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_ivpn2 = '0;
    req_asid  = '0;
    w_valid   = 1'b0;
    for (int i = 0; i < NE; i++)
      mem[i] = mk(19'h7FF00 + 19'(i), 16'h0, 8'hFF, 1'b0);
    mem[9] = mk(19'h00123, 16'h0, 8'd5, 1'b0);
    tick();
    tick();
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_hit", 32'(resp_hit), 32'd0);
    chk("rst_resp_index", 32'(resp_index), 32'd0);
    chk("rst_grp_rd_en", 32'(grp_rd_en), 32'd0);
    chk("rst_grp_rd_index", 32'(grp_rd_index), 32'd0);
    reset = 1'b0;
    tick();

    // Basic hit in group 2
    set_req(1, 1'b1, 19'h00123, 8'd5);
    #1;
    chk("t1_grant_en", 32'(grp_rd_en), 32'd1);
    chk("t1_grant_idx", 32'(grp_rd_index), 32'd0);
    wait_resp("t1", 1, 4, 1'b1, 6'd9);
    req_valid = '0;
    quiet("t1_pulse");

    // ASID mismatch -> full miss
    set_req(1, 1'b1, 19'h00123, 8'd6);
    wait_resp("t2_miss", 1, 17, 1'b0, 6'd0);
    req_valid = '0;
    quiet("t2_miss_pulse");

    // Global entry ignores ASID
    mem[9][0] = 1'b1;
    set_req(1, 1'b1, 19'h00123, 8'd6);
    wait_resp("t2_glob", 1, 4, 1'b1, 6'd9);
    req_valid = '0;
    quiet("t2_glob_pulse");

    // PageMask, lowest slot wins over 10 and 11
    mem[9]  = mk(19'h00123, 16'h0003, 8'd5, 1'b0);
    mem[10] = mk(19'h00122, 16'h0000, 8'd5, 1'b0);
    mem[11] = mk(19'h00122, 16'h0000, 8'd9, 1'b1);
    set_req(0, 1'b1, 19'h00122, 8'd5);
    wait_resp("t2_mask", 0, 4, 1'b1, 6'd9);
    req_valid = '0;
    quiet("t2_mask_pulse");

    // Hit in the last entry of the last group
    mem[63] = mk(19'h3ABCD, 16'h0, 8'd7, 1'b0);
    set_req(2, 1'b1, 19'h3ABCD, 8'd7);
    wait_resp("t2_last", 2, 17, 1'b1, 6'd63);
    req_valid = '0;
    quiet("t2_last_pulse");

    mem[9]  = mk(19'h00123, 16'h0, 8'd5, 1'b0);
    mem[10] = mk(19'h7FF0A, 16'h0, 8'hFF, 1'b0);
    mem[11] = mk(19'h7FF0B, 16'h0, 8'hFF, 1'b0);

    // Round-robin fairness with all channels missing
    set_req(0, 1'b1, 19'h00AAA, 8'd1);
    set_req(1, 1'b1, 19'h00AAB, 8'd1);
    set_req(2, 1'b1, 19'h00AAC, 8'd1);
    wait_resp("t3_a", 0, 17, 1'b0, 6'd0);
    wait_resp("t3_b", 1, 18, 1'b0, 6'd0);
    wait_resp("t3_c", 2, 18, 1'b0, 6'd0);
    wait_resp("t3_d", 0, 18, 1'b0, 6'd0);
    req_valid = '0;
    quiet("t3_pulse");

    // Write while comparing the hitting group restarts the scan
    set_req(2, 1'b1, 19'h00123, 8'd5);
    tick();
    tick();
    tick();
    w_valid = 1'b1;
    chk("t4_early", 32'(resp_valid), 32'd0);
    tick();
    w_valid = 1'b0;
    #1;
    chk("t4_discard", 32'(resp_valid), 32'd0);
    chk("t4_reissue_en", 32'(grp_rd_en), 32'd1);
    chk("t4_reissue_idx", 32'(grp_rd_index), 32'd0);
    wait_resp("t4", 2, 4, 1'b1, 6'd9);
    req_valid = '0;
    quiet("t4_pulse");

    // Owner withdraws mid-scan, waiting channel gets served
    set_req(0, 1'b1, 19'h00AAA, 8'd1);
    set_req(2, 1'b1, 19'h00123, 8'd5);
    for (int i = 0; i < 5; i++) tick();
    req_valid[0] = 1'b0;
    chk("t5_drop", 32'(resp_valid), 32'd0);
    tick();
    chk("t5_no_resp", 32'(resp_valid), 32'd0);
    chk("t5_regrant_en", 32'(grp_rd_en), 32'd1);
    chk("t5_regrant_idx", 32'(grp_rd_index), 32'd0);
    wait_resp("t5", 2, 4, 1'b1, 6'd9);
    req_valid = '0;
    quiet("t5_pulse");

    // Asynchronous reset mid-scan
    set_req(0, 1'b1, 19'h00AAA, 8'd1);
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(resp_valid), 32'd0);
    chk("t6_rst_hit", 32'(resp_hit), 32'd0);
    chk("t6_rst_index", 32'(resp_index), 32'd0);
    chk("t6_rst_en", 32'(grp_rd_en), 32'd0);
    chk("t6_rst_idx", 32'(grp_rd_index), 32'd0);
    tick();
    chk("t6_rst_hold", 32'(resp_valid), 32'd0);
    reset = 1'b0;
    set_req(0, 1'b1, 19'h00123, 8'd5);
    #1;
    chk("t6_grant_en", 32'(grp_rd_en), 32'd1);
    wait_resp("t6", 0, 4, 1'b1, 6'd9);
    req_valid = '0;
    quiet("t6_pulse");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
